// File: rtl/usr_pkg.sv
// Purpose: shared mode-select encodings for the universal shift register.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package usr_pkg;

    localparam logic [1:0] SEL_HOLD = 2'b00;
    localparam logic [1:0] SEL_SHR  = 2'b01;
    localparam logic [1:0] SEL_SHL  = 2'b10;
    localparam logic [1:0] SEL_LOAD = 2'b11;

    typedef enum logic [1:0] {
        MODE_HOLD = SEL_HOLD,
        MODE_SHR  = SEL_SHR,
        MODE_SHL  = SEL_SHL,
        MODE_LOAD = SEL_LOAD
    } usr_mode_t;

endpackage

// File: rtl/usr_if.sv
// Purpose: control/data bundle for the universal shift register (sel, d in; q out).
// Latency: n/a (wiring only).
// Backpressure: none; the register accepts a new mode every clock.
//   sel : 2-bit mode select (hold / shift right / shift left / load)
//   d   : WIDTH-bit parallel load data, d[0] is the serial input for shifts
//   q   : WIDTH-bit registered contents
interface usr_if #(
    parameter int WIDTH = 4
);
    import usr_pkg::*;

    logic [1:0]       sel;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;

    // master drives the controls and observes the register
    modport master (output sel, output d, input q);
    // slave is the shift register itself
    modport slave  (input sel, input d, output q);

endinterface

// File: rtl/usr_bit_cell.sv
// Purpose: one bit of the universal shift register: 4:1 next-state mux plus flop.
// Latency: one clock from sel/neighbour inputs to q_bit.
// Backpressure: none; updates every clock, cleared asynchronously by reset.
//   clk, reset : clock and async active-high clear
//   sel        : mode select
//   right_in   : value shifted in on SHR (upper neighbour, or serial in at MSB)
//   left_in    : value shifted in on SHL (lower neighbour, or serial in at LSB)
//   load_in    : parallel load bit
//   q_bit      : stored bit
module usr_bit_cell
    import usr_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] sel,
    input  logic       right_in,
    input  logic       left_in,
    input  logic       load_in,
    output logic       q_bit
);

    logic nxt;

    always_comb begin
        nxt = q_bit;
        case (sel)
            SEL_HOLD: nxt = q_bit;
            SEL_SHR:  nxt = right_in;
            SEL_SHL:  nxt = left_in;
            SEL_LOAD: nxt = load_in;
            default:  nxt = q_bit;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_bit <= 1'b0;
        end else begin
            q_bit <= nxt;
        end
    end

endmodule

// File: rtl/universal_shift_register.sv
// Purpose: WIDTH-bit universal shift register (hold / shift right / shift left / load).
// Latency: one clock from sel/d to q; q is purely registered.
// Backpressure: none; a new mode is accepted every clock, shifted-out bits are lost.
//   clk   : rising-edge clock
//   reset : asynchronous active-high clear of q
//   bus   : usr_if slave (sel, d in; q out)
module universal_shift_register
    import usr_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic clk,
    input  logic reset,
    usr_if.slave bus
);

    logic [WIDTH-1:0] q_int;
    logic [1:0]       sel_i;
    logic [WIDTH-1:0] d_i;

    assign sel_i = bus.sel;
    assign d_i   = bus.d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        logic right_nb;
        logic left_nb;

        // SHR moves bits toward the LSB, so each bit takes its upper neighbour;
        // the MSB has no upper neighbour and takes the serial input instead.
        if (i == WIDTH - 1) begin : g_msb
            assign right_nb = d_i[0];
        end else begin : g_mid_r
            assign right_nb = q_int[i+1];
        end

        // SHL is the mirror image: the LSB takes the serial input.
        if (i == 0) begin : g_lsb
            assign left_nb = d_i[0];
        end else begin : g_mid_l
            assign left_nb = q_int[i-1];
        end

        usr_bit_cell u_cell (
            .clk      (clk),
            .reset    (reset),
            .sel      (sel_i),
            .right_in (right_nb),
            .left_in  (left_nb),
            .load_in  (d_i[i]),
            .q_bit    (q_int[i])
        );
    end

    assign bus.q = q_int;

endmodule

// File: tb/tb_universal_shift_register.sv
// Purpose: self-checking bench for universal_shift_register at WIDTH=4.
// Latency: expects q one clock after sel/d are presented; async clear at once.
// Backpressure: n/a.
module tb_universal_shift_register;
    import usr_pkg::*;

    localparam int W = 4;

    logic clk;
    logic reset;

    usr_if #(.WIDTH(W)) bus ();

    universal_shift_register #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] sb[$];

    // Pop the oldest expected value and compare it against q.
    task automatic check(input string tag);
        logic [W-1:0] exp;
        logic [W-1:0] got;
        got = bus.q;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("FAIL %s scoreboard empty, q=%b", tag, got);
        end else begin
            exp = sb.pop_front();
            assert (got === exp) else begin
                bad++;
                $error("FAIL %s q=%b expected=%b", tag, got, exp);
            end
        end
    endtask

    // Drive one mode on the falling edge, then check q just after the next rising edge.
    task automatic step(input logic [1:0] s, input logic [W-1:0] dv,
                        input logic [W-1:0] exp, input string tag);
        @(negedge clk);
        bus.sel = s;
        bus.d   = dv;
        sb.push_back(exp);
        @(posedge clk);
        #1;
        check(tag);
    endtask

    initial begin
        reset   = 1'b0;
        bus.sel = SEL_LOAD;
        bus.d   = 4'b1111;

        // Asynchronous clear before any clock edge (first rising edge is at t=5).
        #2;
        reset = 1'b1;
        #1;
        sb.push_back(4'b0000);
        check("reset_async_no_edge");

        // Clear holds across edges even with LOAD of all ones presented.
        repeat (2) @(posedge clk);
        #1;
        sb.push_back(4'b0000);
        check("reset_hold_over_edges");

        @(negedge clk);
        reset = 1'b0;

        step(SEL_LOAD, 4'b1010, 4'b1010, "load_1010");
        step(SEL_SHR,  4'b0001, 4'b1101, "shr_in1");
        step(SEL_SHL,  4'b0001, 4'b1011, "shl_in1");
        step(SEL_HOLD, 4'b0101, 4'b1011, "hold_1");
        step(SEL_HOLD, 4'b1110, 4'b1011, "hold_2");
        step(SEL_HOLD, 4'b0000, 4'b1011, "hold_3");

        step(SEL_LOAD, 4'b1111, 4'b1111, "load_1111");
        step(SEL_SHR,  4'b0000, 4'b0111, "shr0_1");
        step(SEL_SHR,  4'b0000, 4'b0011, "shr0_2");
        step(SEL_SHR,  4'b0000, 4'b0001, "shr0_3");
        step(SEL_SHR,  4'b0000, 4'b0000, "shr0_4");

        // Only d[0] feeds a shift; the upper d bits must be ignored.
        step(SEL_LOAD, 4'b0110, 4'b0110, "load_0110");
        step(SEL_SHR,  4'b1110, 4'b0011, "shr_ignore_upper");
        step(SEL_SHL,  4'b1110, 4'b0110, "shl_ignore_upper");
        step(SEL_SHL,  4'b0001, 4'b1101, "shl_msb_lost");

        // Reset asserted mid-sequence, between clock edges.
        step(SEL_LOAD, 4'b1111, 4'b1111, "load_1111_b");
        step(SEL_SHR,  4'b0000, 4'b0111, "shr_mid_1");
        step(SEL_SHR,  4'b0000, 4'b0011, "shr_mid_2");
        #2;
        reset = 1'b1;
        #1;
        sb.push_back(4'b0000);
        check("reset_mid_sequence");

        @(posedge clk);
        #1;
        sb.push_back(4'b0000);
        check("reset_overrides_shr");

        @(negedge clk);
        reset = 1'b0;

        // Shifting resumes from zero after release.
        step(SEL_SHL,  4'b0001, 4'b0001, "resume_shl_1");
        step(SEL_SHL,  4'b0001, 4'b0011, "resume_shl_2");
        step(SEL_SHR,  4'b0001, 4'b1001, "resume_shr");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
